// File: rtl/ps2_keyboard_ascii.sv
// ps2_keyboard_ascii: PS/2 Set-2 receiver and decoder that emits one ASCII/control byte per key press.
module ps2_keyboard_ascii #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       inClock,
  input  logic       inResetNeg,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] outASCIIData,
  output logic       outWriteData,
  output logic       outFrameError,
  output logic       outShift
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [1:0] clk_sync_q, dat_sync_q;
  logic clk_prev_q, sclk, sdat, fall;
  logic [8:0] sr_q, sr_d;
  logic [9:0] frame;
  logic [3:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic byte_valid_q, byte_valid_d, ferr_q, ferr_d;
  logic [7:0] byte_q, byte_d, ascii_q, ascii_d;
  logic brk_q, brk_d, ext_q, ext_d, lshift_q, lshift_d, rshift_q, rshift_d, wr_q, wr_d;
  logic [16:0] map;
  logic [8:0] emap;
  function automatic logic [16:0] lut(input logic [7:0] c);
    case (c)
      8'h1C: lut = {1'b1, "a", "A"};  8'h32: lut = {1'b1, "b", "B"};
      8'h21: lut = {1'b1, "c", "C"};  8'h23: lut = {1'b1, "d", "D"};
      8'h24: lut = {1'b1, "e", "E"};  8'h2B: lut = {1'b1, "f", "F"};
      8'h34: lut = {1'b1, "g", "G"};  8'h33: lut = {1'b1, "h", "H"};
      8'h43: lut = {1'b1, "i", "I"};  8'h3B: lut = {1'b1, "j", "J"};
      8'h42: lut = {1'b1, "k", "K"};  8'h4B: lut = {1'b1, "l", "L"};
      8'h3A: lut = {1'b1, "m", "M"};  8'h31: lut = {1'b1, "n", "N"};
      8'h44: lut = {1'b1, "o", "O"};  8'h4D: lut = {1'b1, "p", "P"};
      8'h15: lut = {1'b1, "q", "Q"};  8'h2D: lut = {1'b1, "r", "R"};
      8'h1B: lut = {1'b1, "s", "S"};  8'h2C: lut = {1'b1, "t", "T"};
      8'h3C: lut = {1'b1, "u", "U"};  8'h2A: lut = {1'b1, "v", "V"};
      8'h1D: lut = {1'b1, "w", "W"};  8'h22: lut = {1'b1, "x", "X"};
      8'h35: lut = {1'b1, "y", "Y"};  8'h1A: lut = {1'b1, "z", "Z"};
      8'h45: lut = {1'b1, "0", ")"};  8'h16: lut = {1'b1, "1", "!"};
      8'h1E: lut = {1'b1, "2", "@"};  8'h26: lut = {1'b1, "3", "#"};
      8'h25: lut = {1'b1, "4", "$"};  8'h2E: lut = {1'b1, "5", "%"};
      8'h36: lut = {1'b1, "6", "^"};  8'h3D: lut = {1'b1, "7", "&"};
      8'h3E: lut = {1'b1, "8", "*"};  8'h46: lut = {1'b1, "9", "("};
      8'h29: lut = {1'b1, " ", " "};  8'h41: lut = {1'b1, ",", "<"};
      8'h49: lut = {1'b1, ".", ">"};  8'h4A: lut = {1'b1, "/", "?"};
      8'h4E: lut = {1'b1, "-", "_"};  8'h55: lut = {1'b1, "=", "+"};
      8'h5A: lut = {1'b1, 8'h0D, 8'h0D};
      8'h76: lut = {1'b1, 8'h1B, 8'h1B};
      8'h66: lut = {1'b1, 8'h08, 8'h08};
      default: lut = 17'h0;
    endcase
  endfunction
  function automatic logic [8:0] elut(input logic [7:0] c);
    case (c)
      8'h75: elut = {1'b1, 8'h11};
      8'h72: elut = {1'b1, 8'h12};
      8'h6B: elut = {1'b1, 8'h13};
      8'h74: elut = {1'b1, 8'h14};
      8'h5A: elut = {1'b1, 8'h0D};
      default: elut = 9'h0;
    endcase
  endfunction
  assign sclk = clk_sync_q[1];
  assign sdat = dat_sync_q[1];
  assign fall = clk_prev_q & ~sclk;
  assign frame = {sdat, sr_q};
  // Receiver: start bit in IDLE, then 8 data + odd parity + stop, each shifted in at the top.
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    timer_d = timer_q;
    byte_valid_d = 1'b0;
    byte_d = byte_q;
    ferr_d = 1'b0;
    if (state_q == IDLE) begin
      if (fall) begin
        ferr_d = sdat;
        state_d = sdat ? IDLE : RECV;
        cnt_d = '0;
        timer_d = '0;
      end
    end else if (fall) begin
      sr_d = frame[9:1];
      cnt_d = cnt_q + 4'd1;
      timer_d = '0;
      if (cnt_q == 4'd9) begin
        state_d = IDLE;
        byte_valid_d = frame[9] & (^frame[8:0]);
        ferr_d = ~(frame[9] & (^frame[8:0]));
        byte_d = frame[7:0];
      end
    end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
      ferr_d = 1'b1;
      state_d = IDLE;
    end else begin
      timer_d = timer_q + 1'b1;
    end
  end
  assign map = lut(byte_q);
  assign emap = elut(byte_q);
  // Decoder: prefixes latch into brk/ext and are consumed by the next ordinary code.
  always_comb begin
    brk_d = brk_q;
    ext_d = ext_q;
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    wr_d = 1'b0;
    ascii_d = ascii_q;
    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        lshift_d = (!ext_q && byte_q == 8'h12) ? !brk_q : lshift_q;
        rshift_d = (!ext_q && byte_q == 8'h59) ? !brk_q : rshift_q;
        wr_d = !brk_q && (ext_q ? emap[8] : map[16]);
        ascii_d = !wr_d ? ascii_q : ext_q ? emap[7:0] : (lshift_q | rshift_q) ? map[7:0] : map[15:8];
      end
    end
  end
  always_ff @(posedge inClock or negedge inResetNeg) begin
    if (!inResetNeg) begin
      clk_sync_q <= 2'b00;
      dat_sync_q <= 2'b00;
      clk_prev_q <= 1'b0;
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      timer_q <= '0;
      byte_valid_q <= 1'b0;
      byte_q <= '0;
      ferr_q <= 1'b0;
      brk_q <= 1'b0;
      ext_q <= 1'b0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      wr_q <= 1'b0;
      ascii_q <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= sclk;
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      timer_q <= timer_d;
      byte_valid_q <= byte_valid_d;
      byte_q <= byte_d;
      ferr_q <= ferr_d;
      brk_q <= brk_d;
      ext_q <= ext_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      wr_q <= wr_d;
      ascii_q <= ascii_d;
    end
  end
  assign outASCIIData = ascii_q;
  assign outWriteData = wr_q;
  assign outFrameError = ferr_q;
  assign outShift = lshift_q | rshift_q;
endmodule

// File: tb/tb_ps2_keyboard_ascii.sv
// tb_ps2_keyboard_ascii: directed PS/2 frames with a queue-based scoreboard for strobes and frame errors.
module tb_ps2_keyboard_ascii;
  localparam int TO = 300;
  localparam int H = 8;
  typedef struct {logic err; logic [7:0] val; int at;} exp_t;
  logic clk = 0, rst_n = 0, ps2_clk = 1, ps2_dat = 1;
  logic [7:0] ascii;
  logic wr, ferr, shift;
  int cyc = 0, total = 0, bad = 0;
  exp_t q[$];
  ps2_keyboard_ascii #(.TIMEOUT_CYCLES(TO)) dut (
    .inClock(clk), .inResetNeg(rst_n), .PS2_CLK(ps2_clk), .PS2_DAT(ps2_dat),
    .outASCIIData(ascii), .outWriteData(wr), .outFrameError(ferr), .outShift(shift)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic push(input logic err, input logic [7:0] val, input int at);
    exp_t e;
    e.err = err; e.val = val; e.at = at;
    q.push_back(e);
  endtask
  // exp: -1 nothing, 0..255 expected byte, 256 frame error; nbits < 11 sends a truncated frame
  task automatic frame(input logic [7:0] d, input bit badpar, input int exp, input int nbits = 11);
    logic [10:0] bits;
    bits = {1'b1, ~^d ^ badpar, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_dat = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 0;
      if (i == 10 && exp >= 0) push(exp == 256, exp[7:0], cyc + (exp == 256 ? 3 : 4));
      repeat (H) @(negedge clk);
      ps2_clk = 1;
    end
    repeat (2 * H) @(negedge clk);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (wr || ferr)) begin
        if (q.size() == 0) begin
          chk("unexpected_event", {23'd0, ferr, ascii}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event", {ferr, ferr ? 8'h00 : ascii}, {e.err, e.err ? 8'h00 : e.val});
          if (e.at >= 0) chk("latency", cyc, e.at);
        end
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ascii", ascii, 0);
    chk("rst_wr", wr, 0);
    chk("rst_ferr", ferr, 0);
    chk("rst_shift", shift, 0);
    rst_n = 1;
    repeat (4) @(negedge clk);
    frame(8'h1C, 0, 8'h61);
    frame(8'hF0, 0, -1);
    frame(8'h1C, 0, -1);
    frame(8'h12, 0, -1);
    chk("shift_on", shift, 1);
    frame(8'h1C, 0, 8'h41);
    frame(8'hF0, 0, -1);
    frame(8'h1C, 0, -1);
    chk("shift_held", shift, 1);
    frame(8'h16, 0, 8'h21);
    frame(8'hF0, 0, -1);
    frame(8'h12, 0, -1);
    chk("shift_off", shift, 0);
    frame(8'h1C, 0, 8'h61);
    frame(8'h1C, 0, 8'h61);
    frame(8'hE0, 0, -1);
    frame(8'h75, 0, 8'h11);
    frame(8'hE0, 0, -1);
    frame(8'hF0, 0, -1);
    frame(8'h75, 0, -1);
    frame(8'hE0, 0, -1);
    frame(8'h6B, 0, 8'h13);
    frame(8'hE0, 0, -1);
    frame(8'h12, 0, -1);
    chk("fake_shift", shift, 0);
    frame(8'h66, 0, 8'h08);
    frame(8'h16, 1, 256);
    frame(8'h16, 0, 8'h31);
    push(1, 8'h00, -1);
    frame(8'h5A, 0, -1, 5);
    repeat (TO + 50) @(negedge clk);
    frame(8'h5A, 0, 8'h0D);
    frame(8'h59, 0, -1);
    chk("rshift_on", shift, 1);
    frame(8'h4A, 0, 8'h3F);
    frame(8'h76, 0, -1, 4);
    rst_n = 0;
    #1;
    chk("mid_rst_ascii", ascii, 0);
    chk("mid_rst_shift", shift, 0);
    chk("mid_rst_wr", wr, 0);
    chk("mid_rst_ferr", ferr, 0);
    ps2_clk = 1;
    ps2_dat = 1;
    repeat (5) @(negedge clk);
    rst_n = 1;
    repeat (5) @(negedge clk);
    frame(8'h76, 0, 8'h1B);
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
